// File: rtl/shoe_dealer.sv
// shoe_dealer: multi-deck card shoe with an LFSR-driven Fisher-Yates shuffle
// and a one-card-per-request deal handshake.
// Optional feature macro: SHOE_CARD_VALUE_EN adds the card_value output.
module shoe_dealer #(
   parameter int          NUM_DECKS  = 1,
   parameter int          CUT_REMAIN = 15,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   localparam int         N          = 52 * NUM_DECKS,
   localparam int         CL_W       = $clog2(N + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            shuffle_req,
   input  logic            deal_req,
   output logic [5:0]      card,
   output logic            deal_valid,
   output logic            load_flag,
   output logic            shuffle_busy,
   output logic [CL_W-1:0] cards_left,
   output logic            cut_reached,
   output logic            empty
`ifdef SHOE_CARD_VALUE_EN
   ,
   output logic [3:0]      card_value
`endif
);

   localparam int          IW        = $clog2(N);
   localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   localparam logic [2:0] EMPTY   = 3'd0;
   localparam logic [2:0] FILL    = 3'd1;
   localparam logic [2:0] SHUF_RD = 3'd2;
   localparam logic [2:0] SHUF_WR = 3'd3;
   localparam logic [2:0] READY   = 3'd4;

   logic [2:0]    state;
   logic [15:0]   lfsr;
   logic [15:0]   lfsr_next;
   logic [IW-1:0] i;
   logic [IW-1:0] j;
   logic [IW-1:0] ptr;
   logic [IW-1:0] mask;
   logic [IW-1:0] r;
   logic [5:0]    fill_val;
   logic [5:0]    rd_i;
   logic [5:0]    rd_j;
   logic [5:0]    ram [N];

`ifdef SHOE_CARD_VALUE_EN
   // Blackjack value of a card: ace 11, 2..10 face value, J/Q/K 10.
   function automatic logic [3:0] value_of(input logic [5:0] c);
      logic [5:0] rank;
      if (c >= 6'd39)      rank = c - 6'd39;
      else if (c >= 6'd26) rank = c - 6'd26;
      else if (c >= 6'd13) rank = c - 6'd13;
      else                 rank = c;
      if (rank == 6'd0)      value_of = 4'd11;
      else if (rank <= 6'd9) value_of = rank[3:0] + 4'd1;
      else                   value_of = 4'd10;
   endfunction
`endif

   // Galois LFSR step, taps 16'hB400; never reaches zero from a nonzero seed.
   always_comb begin
      lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // Rejection-sampling draw: smear i's leading one down to get 2^ceil(log2(i+1))-1.
   always_comb begin
      mask = i;
      for (int unsigned k = 1; k < IW; k++) mask = mask | (i >> k);
      r = lfsr[IW-1:0] & mask;
   end

   assign shuffle_busy = (state == FILL) || (state == SHUF_RD) || (state == SHUF_WR);
   assign empty        = (cards_left == '0);
   assign cut_reached  = (state == READY) && (32'(cards_left) <= 32'(CUT_REMAIN));

   // Card RAM: sequential fill, then two-entry swap per shuffle step.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == FILL) begin
            ram[i] <= fill_val;
         end else if (state == SHUF_WR) begin
            ram[i] <= rd_j;
            ram[j] <= rd_i;
         end
      end
   end

   // Control FSM, LFSR, deal pointer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         lfsr       <= SEED_EFF;
         i          <= '0;
         j          <= '0;
         ptr        <= '0;
         fill_val   <= '0;
         rd_i       <= '0;
         rd_j       <= '0;
         cards_left <= '0;
         card       <= '0;
         deal_valid <= 1'b0;
         load_flag  <= 1'b0;
`ifdef SHOE_CARD_VALUE_EN
         card_value <= '0;
`endif
      end else begin
         lfsr       <= lfsr_next;
         deal_valid <= 1'b0;
         load_flag  <= 1'b0;
         case (state)
            EMPTY, READY: begin
               if (shuffle_req) begin
                  state      <= FILL;
                  i          <= '0;
                  fill_val   <= '0;
                  cards_left <= '0;
               end else if ((state == READY) && deal_req && (cards_left != '0)) begin
                  deal_valid <= 1'b1;
                  card       <= ram[ptr];
`ifdef SHOE_CARD_VALUE_EN
                  card_value <= value_of(ram[ptr]);
`endif
                  ptr        <= ptr + 1'b1;
                  cards_left <= cards_left - 1'b1;
               end
            end
            FILL: begin
               fill_val <= (fill_val == 6'd51) ? 6'd0 : fill_val + 6'd1;
               if (i == IW'(N - 1)) state <= SHUF_RD;
               else                 i     <= i + 1'b1;
            end
            SHUF_RD: begin
               if (r <= i) begin
                  j     <= r;
                  rd_i  <= ram[i];
                  rd_j  <= ram[r];
                  state <= SHUF_WR;
               end
            end
            SHUF_WR: begin
               if (i == '0) begin
                  state      <= READY;
                  load_flag  <= 1'b1;
                  cards_left <= CL_W'(N);
                  ptr        <= '0;
               end else begin
                  i     <= i - 1'b1;
                  state <= SHUF_RD;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_shoe_dealer.sv
// tb_shoe_dealer: directed bench for shoe_dealer with a deal scoreboard.
// Two instances: one single-deck, one double-deck shoe.
module tb_shoe_dealer;

   typedef struct {
      int left;
      int card;
      bit chk_card;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst1 = 1'b1, shuffle_req1 = 1'b0, deal_req1 = 1'b0;
   logic       rst2 = 1'b1, shuffle_req2 = 1'b0, deal_req2 = 1'b0;
   logic [5:0] card1, card2;
   logic       deal_valid1, load_flag1, shuffle_busy1, cut_reached1, empty1;
   logic       deal_valid2, load_flag2, shuffle_busy2, cut_reached2, empty2;
   logic [5:0] cards_left1;
   logic [6:0] cards_left2;
`ifdef SHOE_CARD_VALUE_EN
   logic [3:0] card_value1, card_value2;
`endif

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t q1[$];
   exp_t q2[$];
   int   cur_seq[$];
   int   ref_seq[$];
   int   cnt1[52];
   int   cnt2[52];
   bit   m1_ready = 0, m2_ready = 0;
   int   m1_left = 0, m2_left = 0;
   bit   replay = 0;
   int   ridx = 0;

   shoe_dealer #(.NUM_DECKS(1), .CUT_REMAIN(15), .LFSR_SEED(16'hACE1)) d1 (
      .clk(clk), .rst(rst1), .shuffle_req(shuffle_req1), .deal_req(deal_req1),
      .card(card1), .deal_valid(deal_valid1), .load_flag(load_flag1),
      .shuffle_busy(shuffle_busy1), .cards_left(cards_left1),
      .cut_reached(cut_reached1), .empty(empty1)
`ifdef SHOE_CARD_VALUE_EN
      , .card_value(card_value1)
`endif
   );

   shoe_dealer #(.NUM_DECKS(2), .CUT_REMAIN(15), .LFSR_SEED(16'hACE1)) d2 (
      .clk(clk), .rst(rst2), .shuffle_req(shuffle_req2), .deal_req(deal_req2),
      .card(card2), .deal_valid(deal_valid2), .load_flag(load_flag2),
      .shuffle_busy(shuffle_busy2), .cards_left(cards_left2),
      .cut_reached(cut_reached2), .empty(empty2)
`ifdef SHOE_CARD_VALUE_EN
      , .card_value(card_value2)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int cv_exp(input int c);
      int rank;
      rank = c % 13;
      if (rank == 0) return 11;
      if (rank < 10) return rank + 1;
      return 10;
   endfunction

   // Advance one cycle and score any deal that the previous drive predicted.
   task automatic step();
      exp_t e;
      @(negedge clk);
      check("d1_deal_valid", deal_valid1, q1.size() > 0);
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check("d1_left_after_deal", cards_left1, e.left);
         if (e.chk_card) check("d1_replay_card", card1, e.card);
         cur_seq.push_back(int'(card1));
         if (card1 < 6'd52) cnt1[card1]++;
`ifdef SHOE_CARD_VALUE_EN
         check("d1_card_value", card_value1, cv_exp(int'(card1)));
`endif
      end
      check("d2_deal_valid", deal_valid2, q2.size() > 0);
      if (q2.size() > 0) begin
         e = q2.pop_front();
         check("d2_left_after_deal", cards_left2, e.left);
         if (card2 < 6'd52) cnt2[card2]++;
`ifdef SHOE_CARD_VALUE_EN
         check("d2_card_value", card_value2, cv_exp(int'(card2)));
`endif
      end
   endtask

   task automatic drive1(input bit shuf, input bit deal);
      exp_t e;
      shuffle_req1 = shuf;
      deal_req1    = deal;
      if (shuf) begin
         m1_ready = 0;
         m1_left  = 0;
      end else if (deal && m1_ready && m1_left > 0) begin
         m1_left--;
         e.left     = m1_left;
         e.chk_card = replay;
         e.card     = replay ? ref_seq[ridx] : 0;
         if (replay) ridx++;
         q1.push_back(e);
      end
   endtask

   task automatic drive2(input bit shuf, input bit deal);
      exp_t e;
      shuffle_req2 = shuf;
      deal_req2    = deal;
      if (shuf) begin
         m2_ready = 0;
         m2_left  = 0;
      end else if (deal && m2_ready && m2_left > 0) begin
         m2_left--;
         e.left     = m2_left;
         e.chk_card = 0;
         e.card     = 0;
         q2.push_back(e);
      end
   endtask

   task automatic wait_load1();
      bit got = 0;
      for (int c = 0; c < 5000 && !got; c++) begin
         step();
         if (load_flag1) got = 1;
         else check("d1_busy_while_shuffling", shuffle_busy1, 1);
      end
      check("d1_load_flag_seen", got, 1);
      check("d1_left_at_load", cards_left1, 52);
      check("d1_busy_at_load", shuffle_busy1, 0);
      m1_ready = 1;
      m1_left  = 52;
   endtask

   task automatic wait_load2();
      bit got = 0;
      for (int c = 0; c < 5000 && !got; c++) begin
         step();
         if (load_flag2) got = 1;
         else check("d2_busy_while_shuffling", shuffle_busy2, 1);
      end
      check("d2_load_flag_seen", got, 1);
      check("d2_left_at_load", cards_left2, 104);
      m2_ready = 1;
      m2_left  = 104;
   endtask

   // Reset, ignored deal, shuffle, deal the full single deck.
   task automatic run1();
      int last;
      rst1 = 1'b1;
      drive1(0, 0);
      m1_ready = 0;
      m1_left  = 0;
      repeat (3) step();
      rst1 = 1'b0;
      step();
      check("d1_reset_empty", empty1, 1);
      check("d1_reset_left", cards_left1, 0);
      check("d1_reset_busy", shuffle_busy1, 0);
      check("d1_reset_load", load_flag1, 0);
      check("d1_reset_cut", cut_reached1, 0);
      check("d1_reset_card", card1, 0);
      drive1(0, 1);
      step();
      drive1(1, 0);
      step();
      check("d1_busy_after_req", shuffle_busy1, 1);
      check("d1_left_in_fill", cards_left1, 0);
      drive1(0, 0);
      wait_load1();
      check("d1_cut_after_load", cut_reached1, 0);
      cur_seq.delete();
      for (int v = 0; v < 52; v++) cnt1[v] = 0;
      for (int k = 0; k < 52; k++) begin
         drive1(0, 1);
         step();
      end
      drive1(0, 0);
      check("d1_left_after_52", cards_left1, 0);
      check("d1_empty_after_52", empty1, 1);
      check("d1_cut_after_52", cut_reached1, 1);
      last = (cur_seq.size() > 0) ? cur_seq[cur_seq.size() - 1] : -1;
      drive1(0, 1);
      step();
      drive1(0, 0);
      check("d1_card_held", card1, last);
      for (int v = 0; v < 52; v++) check("d1_perm_count", cnt1[v], 1);
   endtask

   initial begin
      int seen;
      // d2 reset; d1 is held in reset until its own sequence starts.
      repeat (3) step();
      rst2 = 1'b0;
      step();
      check("d2_reset_empty", empty2, 1);
      check("d2_reset_left", cards_left2, 0);
      check("d2_reset_busy", shuffle_busy2, 0);

      run1();
      ref_seq = cur_seq;

      // Double deck: cut card threshold and two-of-each permutation.
      drive2(1, 0);
      step();
      drive2(0, 0);
      wait_load2();
      for (int v = 0; v < 52; v++) cnt2[v] = 0;
      for (int k = 0; k < 88; k++) begin
         drive2(0, 1);
         step();
      end
      drive2(0, 0);
      check("d2_left_after_88", cards_left2, 16);
      check("d2_cut_after_88", cut_reached2, 0);
      drive2(0, 1);
      step();
      drive2(0, 0);
      check("d2_left_after_89", cards_left2, 15);
      check("d2_cut_after_89", cut_reached2, 1);
      for (int k = 0; k < 15; k++) begin
         drive2(0, 1);
         step();
      end
      drive2(0, 0);
      check("d2_empty_after_104", empty2, 1);
      for (int v = 0; v < 52; v++) check("d2_perm_count", cnt2[v], 2);

      // Reset mid-shuffle aborts without load_flag.
      drive1(1, 0);
      step();
      drive1(0, 0);
      for (int k = 0; k < 60; k++) begin
         step();
         check("d1_busy_before_abort", shuffle_busy1, 1);
      end
      rst1 = 1'b1;
      step();
      rst1 = 1'b0;
      check("d1_abort_empty", empty1, 1);
      check("d1_abort_busy", shuffle_busy1, 0);
      check("d1_abort_left", cards_left1, 0);
      seen = 0;
      for (int k = 0; k < 600; k++) begin
         step();
         if (load_flag1) seen++;
      end
      check("d1_no_load_after_abort", seen, 0);

      // shuffle_req held through part of FILL gives a single shuffle.
      for (int k = 0; k < 30; k++) begin
         drive1(1, 0);
         step();
      end
      drive1(0, 0);
      wait_load1();
      seen = 0;
      for (int k = 0; k < 600; k++) begin
         step();
         if (load_flag1) seen++;
      end
      check("d1_single_load_for_held_req", seen, 0);

      // Shuffle request outranks a same-cycle deal.
      for (int k = 0; k < 12; k++) begin
         drive1(0, 1);
         step();
      end
      drive1(0, 0);
      check("d1_left_40", cards_left1, 40);
      drive1(1, 1);
      step();
      drive1(0, 0);
      check("d1_busy_after_collide", shuffle_busy1, 1);
      wait_load1();

      // Identical seed and timing reproduce the first deal sequence.
      replay = 1;
      ridx   = 0;
      run1();
      replay = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
